// File: rtl/ppg_disp_pkg.sv
// Shared definitions for the ping-pong score display: FSM encoding, glyphs, slot indices.
package ppg_disp_pkg;

    typedef enum logic [1:0] {
        ST_SHOW  = 2'd0,
        ST_FLASH = 2'd1,
        ST_OVER  = 2'd2
    } disp_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Slot 0 is the rightmost digit (player 2), slot 3 the leftmost (player 1).
    localparam logic [1:0] SLOT_P2      = 2'd0;
    localparam logic [1:0] SLOT_DASH_LO = 2'd1;
    localparam logic [1:0] SLOT_DASH_HI = 2'd2;
    localparam logic [1:0] SLOT_P1      = 2'd3;

    function automatic logic [3:0] slot_to_dig_sel(input logic [1:0] slot);
        return ~(4'b0001 << slot);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 0-7 digit decoder to active-low {dp,g,f,e,d,c,b,a}; blank forces all segments off.
module seg7_decode
    import ppg_disp_pkg::*;
(
    input  logic [2:0] value,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (value)
                3'd0: seg = 8'hC0;
                3'd1: seg = 8'hF9;
                3'd2: seg = 8'hA4;
                3'd3: seg = 8'hB0;
                3'd4: seg = 8'h99;
                3'd5: seg = 8'h92;
                3'd6: seg = 8'h82;
                3'd7: seg = 8'hF8;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_display.sv
// Multiplexed score display with point-flash and game-over blink, plus ball LED driver.
module score_display
    import ppg_disp_pkg::*;
#(
    parameter int         SCAN_DIV    = 50000,
    parameter int         FLASH_TICKS = 6,
    parameter logic [2:0] WIN_SCORE   = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_2Hz,
    input  logic [7:0] position,
    input  logic [2:0] score_player1,
    input  logic [2:0] score_player2,
    output logic [7:0] led,
    output logic [7:0] seg,
    output logic [3:0] dig_sel,
    output logic       game_over
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FCNT_W = $clog2(FLASH_TICKS + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FCNT_W-1:0] FCNT_END  = FCNT_W'(FLASH_TICKS);

    logic              sync1, sync2, sync3;
    logic              tick;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        slot;
    logic [2:0]        p1_q, p2_q;
    disp_state_t       state, state_n;
    logic [1:0]        flash_mask, flash_mask_n;
    logic [FCNT_W-1:0] fcnt, fcnt_n;
    logic              inc1, inc2, dec1, dec2, win1, win2;
    logic              blank1, blank2;
    logic [2:0]        dec_value;
    logic              dec_blank;
    logic [7:0]        dec_seg, seg_n, led_n;

    assign tick = sync2 & ~sync3;
    assign inc1 = score_player1 > p1_q;
    assign inc2 = score_player2 > p2_q;
    assign dec1 = score_player1 < p1_q;
    assign dec2 = score_player2 < p2_q;
    assign win1 = score_player1 == WIN_SCORE;
    assign win2 = score_player2 == WIN_SCORE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_SHOW;
            flash_mask <= 2'b00;
            fcnt       <= '0;
        end else begin
            state      <= state_n;
            flash_mask <= flash_mask_n;
            fcnt       <= fcnt_n;
        end
    end

    // Restart beats everything, an ongoing game-over only blinks, a win beats a new point.
    always_comb begin
        state_n      = state;
        flash_mask_n = flash_mask;
        fcnt_n       = fcnt;
        if (dec1 || dec2) begin
            state_n      = ST_SHOW;
            flash_mask_n = 2'b00;
            fcnt_n       = '0;
        end else if (state == ST_OVER) begin
            if (tick) fcnt_n = fcnt ^ FCNT_W'(1);
        end else if (win1 || win2) begin
            state_n      = ST_OVER;
            flash_mask_n = {win2, win1};
            fcnt_n       = '0;
        end else if (inc1 || inc2) begin
            state_n      = ST_FLASH;
            flash_mask_n = flash_mask | {inc2, inc1};
            fcnt_n       = '0;
        end else if (state == ST_FLASH && tick) begin
            if (fcnt + FCNT_W'(1) == FCNT_END) begin
                state_n      = ST_SHOW;
                flash_mask_n = 2'b00;
                fcnt_n       = '0;
            end else begin
                fcnt_n = fcnt + FCNT_W'(1);
            end
        end
    end

    // Blanking follows the next state so seg agrees with game_over and led on the same edge.
    assign blank1 = flash_mask_n[0] & fcnt_n[0] & (state_n != ST_SHOW);
    assign blank2 = flash_mask_n[1] & fcnt_n[0] & (state_n != ST_SHOW);

    always_comb begin
        dec_value = score_player2;
        dec_blank = blank2;
        if (slot == SLOT_P1) begin
            dec_value = score_player1;
            dec_blank = blank1;
        end
    end

    seg7_decode u_seg7 (
        .value (dec_value),
        .blank (dec_blank),
        .seg   (dec_seg)
    );

    assign seg_n = (slot == SLOT_P1 || slot == SLOT_P2) ? dec_seg : SEG_DASH;
    assign led_n = (state_n == ST_OVER) ? (fcnt_n[0] ? 8'h00 : 8'hFF) : position;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            scan_cnt <= '0;
            slot     <= SLOT_P2;
            p1_q     <= 3'd0;
            p2_q     <= 3'd0;
            seg      <= SEG_BLANK;
            dig_sel  <= 4'b1111;
            led      <= 8'h00;
        end else begin
            sync1 <= clk_2Hz;
            sync2 <= sync1;
            sync3 <= sync2;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                slot     <= slot + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            p1_q    <= score_player1;
            p2_q    <= score_player2;
            seg     <= seg_n;
            dig_sel <= slot_to_dig_sel(slot);
            led     <= led_n;
        end
    end

    assign game_over = (state == ST_OVER);

endmodule

// File: tb/tb_score_display.sv
// Randomized bench for score_display with a behavioural display model and per-cycle compare.
module tb_score_display;

    localparam int         SCAN_DIV    = 4;
    localparam int         FLASH_TICKS = 6;
    localparam logic [2:0] WIN         = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_2Hz = 1'b0;
    logic [7:0] position = 8'h00;
    logic [2:0] score_player1 = 3'd0;
    logic [2:0] score_player2 = 3'd0;
    logic [7:0] led, seg;
    logic [3:0] dig_sel;
    logic       game_over;

    int tests = 0;
    int fails = 0;
    bit tog_en = 1'b0;

    score_display #(.SCAN_DIV(SCAN_DIV), .FLASH_TICKS(FLASH_TICKS), .WIN_SCORE(WIN)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_2Hz       (clk_2Hz),
        .position      (position),
        .score_player1 (score_player1),
        .score_player2 (score_player2),
        .led           (led),
        .seg           (seg),
        .dig_sel       (dig_sel),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    // Scaled-down stand-in for the 2 Hz divider output.
    initial forever begin
        repeat ($urandom_range(3, 6)) @(negedge clk);
        if (tog_en) clk_2Hz = ~clk_2Hz;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: flash and blink progress counted in ticks, slot derived from cycle count.
    logic [7:0] glyph [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    int         m_cyc = 0, m_pq1 = 0, m_pq2 = 0, m_ticks = 0;
    bit         h1 = 0, h2 = 0, h3 = 0, m_over = 0, m_flash = 0;
    bit [1:0]   m_who = 2'b00;
    int         mp1, mp2, mslot;
    bit         mtick, mb1, mb2;
    logic [7:0] e_led = 8'h00, e_seg = 8'hFF;
    logic [3:0] e_dig = 4'b1111;
    logic       e_go = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_pq1 = 0; m_pq2 = 0; m_ticks = 0;
            h1 = 0; h2 = 0; h3 = 0; m_over = 0; m_flash = 0; m_who = 2'b00;
            e_led = 8'h00; e_seg = 8'hFF; e_dig = 4'b1111; e_go = 1'b0;
        end else begin
            mp1 = int'(score_player1);
            mp2 = int'(score_player2);
            mtick = h2 && !h3;
            h3 = h2; h2 = h1; h1 = clk_2Hz;
            m_cyc++;
            if (mp1 < m_pq1 || mp2 < m_pq2) begin
                m_over = 0; m_flash = 0; m_who = 2'b00; m_ticks = 0;
            end else if (m_over) begin
                if (mtick) m_ticks++;
            end else if (mp1 == WIN || mp2 == WIN) begin
                m_over = 1; m_flash = 0; m_who = {mp2 == WIN, mp1 == WIN}; m_ticks = 0;
            end else if (mp1 > m_pq1 || mp2 > m_pq2) begin
                m_who = (m_flash ? m_who : 2'b00) | {mp2 > m_pq2, mp1 > m_pq1};
                m_flash = 1; m_ticks = 0;
            end else if (m_flash && mtick) begin
                m_ticks++;
                if (m_ticks == FLASH_TICKS) begin
                    m_flash = 0; m_who = 2'b00; m_ticks = 0;
                end
            end
            m_pq1 = mp1;
            m_pq2 = mp2;
            mb1 = (m_over || m_flash) && m_who[0] && (m_ticks % 2 == 1);
            mb2 = (m_over || m_flash) && m_who[1] && (m_ticks % 2 == 1);
            mslot = ((m_cyc - 1) / SCAN_DIV) % 4;
            e_dig = 4'b1111;
            e_dig[mslot] = 1'b0;
            if (mslot == 3)      e_seg = mb1 ? 8'hFF : glyph[mp1];
            else if (mslot == 0) e_seg = mb2 ? 8'hFF : glyph[mp2];
            else                 e_seg = 8'hBF;
            e_led = m_over ? ((m_ticks % 2 == 0) ? 8'hFF : 8'h00) : position;
            e_go  = m_over;
        end
    end

    always @(negedge clk) begin
        #2;
        check("led", led, e_led);
        check("seg", seg, e_seg);
        check("dig_sel", {4'h0, dig_sel}, {4'h0, e_dig});
        check("game_over", {7'h0, game_over}, {7'h0, e_go});
    end

    function automatic logic [7:0] rand_pos();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 8'h00 : (8'h01 << r);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #3;
            position = rand_pos();
        end
    endtask

    task automatic set_scores(input int a, input int b);
        @(negedge clk); #3;
        score_player1 = 3'(a);
        score_player2 = 3'(b);
    endtask

    task automatic obs();
        @(negedge clk); #3;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_led"}, led, 8'h00);
        check({tag, "_seg"}, seg, 8'hFF);
        check({tag, "_dig"}, {4'h0, dig_sel}, 8'h0F);
        check({tag, "_go"}, {7'h0, game_over}, 8'h00);
    endtask

    logic [3:0] lit_dig [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] lit_seg [4] = '{8'h92, 8'hBF, 8'hBF, 8'hA4};
    int s1, s2, r;

    initial begin
        #1 rst = 1'b1;
        score_player1 = 3'd2;
        score_player2 = 3'd5;
        obs();
        check_reset_vals("reset");
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            obs();
            check("scan_dig", {4'h0, dig_sel}, {4'h0, lit_dig[k / 4]});
            check("scan_seg", seg, lit_seg[k / 4]);
        end
        tog_en = 1'b1;
        idle(60);

        set_scores(1, 5); idle(10);
        set_scores(2, 5); idle(90);
        set_scores(3, 5); idle(27);
        set_scores(3, 6); idle(100);
        set_scores(4, 6); set_scores(5, 6); idle(20);
        set_scores(0, 0); idle(10);
        set_scores(1, 1); idle(80);

        s1 = 1; s2 = 1;
        repeat (30) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                if (r != 1 && s1 < 6) s1++;
                if (r != 0 && s2 < 6) s2++;
            end else if (r < 8) begin
                s1 = 0; s2 = 0;
            end else if (r == 8) begin
                s1 = 7;
            end else begin
                s2 = 7;
            end
            set_scores(s1, s2);
            idle($urandom_range(3, 60));
            if (s1 == 7 || s2 == 7) begin
                s1 = 0; s2 = 0;
                set_scores(0, 0);
                idle(5);
            end
        end

        set_scores(0, 0); idle(5);
        set_scores(3, 4); idle(20);
        set_scores(0, 0);
        obs();
        check("drop_flash_go", {7'h0, game_over}, 8'h00);
        check("drop_flash_led", led, position);

        set_scores(3, 6); idle(100);
        set_scores(3, 7);
        obs();
        check("win_go", {7'h0, game_over}, 8'h01);
        check("win_led", led, 8'hFF);
        idle(70);
        set_scores(0, 0);
        obs();
        check("drop_over_go", {7'h0, game_over}, 8'h00);
        check("drop_over_led", led, position);

        set_scores(3, 4); set_scores(4, 4); idle(15);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_flash");
        obs();
        position = 8'h10;
        rst = 1'b0;
        obs();
        check("post_rst_led", led, 8'h10);
        idle(40);

        set_scores(7, 4); idle(30);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_over");
        obs();
        rst = 1'b0;
        set_scores(0, 0);
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
